// File: rtl/i2c_master_wb.sv
// i2c_master_wb: single-CSR Wishbone slave driving an open-drain I2C bus, one START/STOP/WRITE/READ primitive per write
//   clk, rst       : system clock, asynchronous active-high reset
//   scl_oe, sda_oe : 1 pulls the pad low, 0 releases it to the pull-up
//   sda_i          : SDA pad level
//   wb_cyc, wb_we, wb_wdata, wb_ack, wb_rdata : CSR access, read = {ready, 22'b0, ack_out, data_out}
module i2c_master_wb #(
    parameter int DW = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_i,
    output logic [31:0] wb_rdata,
    input  logic [31:0] wb_wdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack
);
    typedef enum logic [1:0] {IDLE, STA, STO, XFER} state_t;
    state_t state, state_n;
    logic [DW-1:0] pre;
    logic [5:0] step, step_n;
    logic [8:0] shift, load;
    logic [7:0] data_out;
    logic [1:0] ph;
    logic ack_out, ready, accept, tick, last, upd, scl_n, sda_n;
    logic unused;
    assign unused = ^{wb_wdata[31:14], wb_wdata[11:9]};
    assign ready = state == IDLE;
    assign accept = wb_cyc & wb_we & ~wb_ack & ready;
    assign tick = &pre;
    // step[1:0] is the phase within a slot, step[5:2] the bit slot
    assign last = step == ((state == XFER) ? 6'd35 : 6'd3);
    // lines change on entering a phase, never on the completion tick
    assign upd = accept | (~ready & tick & ~last);
    assign load = wb_wdata[12] ? {8'hFF, wb_wdata[8]} : {wb_wdata[7:0], 1'b1};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = accept ? (wb_wdata[13] ? XFER : wb_wdata[12] ? STO : STA)
                : (~ready & tick & last) ? IDLE : state;
        step_n = accept ? 6'd0 : step + 6'd1;
        ph = step_n[1:0];
        scl_n = scl_oe;
        sda_n = sda_oe;
        if (upd) begin
            scl_n = ph == 2'd1 ? 1'b0 : (ph == 2'd3 && state_n != STO) ? 1'b1 : scl_oe;
            sda_n = state_n == XFER ? (ph == 2'd0 ? ~(accept ? load[8] : shift[8]) : sda_oe)
                  : state_n == STA ? (ph == 2'd0 ? 1'b0 : ph == 2'd2 ? 1'b1 : sda_oe)
                  : (ph == 2'd0 ? 1'b1 : ph == 2'd3 ? 1'b0 : sda_oe);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            step <= '0;
            shift <= '0;
            data_out <= '0;
            ack_out <= 1'b0;
            scl_oe <= 1'b0;
            sda_oe <= 1'b0;
            wb_ack <= 1'b0;
            wb_rdata <= '0;
        end else begin
            wb_ack <= wb_cyc & ~wb_ack;
            wb_rdata <= (wb_cyc & ~wb_ack) ? {ready, 22'b0, ack_out, data_out} : 32'b0;
            scl_oe <= scl_n;
            sda_oe <= sda_n;
            if (accept) begin
                pre <= '0;
                step <= '0;
                shift <= load;
            end else if (!ready) begin
                pre <= pre + DW'(1);
                if (tick) step <= step_n;
                if (tick && state == XFER && step[1:0] == 2'd2) shift <= {shift[7:0], sda_i};
                if (tick && state == XFER && last) {data_out, ack_out} <= shift;
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_wb.sv
// tb_i2c_master_wb: directed plus randomized bench for i2c_master_wb (DW=4) with an open-drain bus and slave model
module tb_i2c_master_wb;
    logic clk = 1'b0, rst = 1'b1;
    logic scl_oe, sda_oe, sda_i, wb_ack, wb_we = 1'b0, wb_cyc = 1'b0, pull = 1'b0;
    logic [31:0] wb_rdata, wb_wdata = '0;
    int checks = 0, fails = 0;
    logic [7:0] exp_data = '0;
    logic exp_ack = 1'b0, exp_scl = 1'b0;

    always #5 clk = ~clk;
    assign sda_i = ~(sda_oe | pull);

    i2c_master_wb #(.DW(4)) dut (
        .clk(clk), .rst(rst), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i),
        .wb_rdata(wb_rdata), .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected {scl_oe, sda_oe} k clocks after the accepting edge, from the I2C phase tables.
    function automatic logic [1:0] exp_lines(input logic [1:0] cmd, input logic [7:0] d, input logic ai,
                                             input int k, input logic prev_scl);
        int n, p, s, q;
        n = cmd[1] ? 36 : 4;
        p = k / 16;
        if (p > n - 1) p = n - 1;
        s = p / 4;
        q = p % 4;
        case (cmd)
            2'd0: return {(p == 0) ? prev_scl : 1'(p >= 3), 1'(p >= 2)};
            2'd1: return {(p == 0) ? prev_scl : 1'b0, 1'(p < 3)};
            2'd2: return {(q == 0 && s == 0) ? prev_scl : 1'(q == 0 || q == 3), (s < 8) ? ~d[7-s] : 1'b0};
            default: return {(q == 0 && s == 0) ? prev_scl : 1'(q == 0 || q == 3), (s < 8) ? 1'b0 : ~ai};
        endcase
    endfunction

    // Slave pulls SDA low: ACK in slot 9 of a WRITE, zero bits of its byte in slots 1-8 of a READ.
    function automatic logic slave_pull(input logic [1:0] cmd, input logic [7:0] d, input logic sa, input int s);
        if (s > 8) return 1'b0;
        if (cmd == 2'd2) return (s == 8) & sa;
        if (cmd == 2'd3) return (s < 8) ? ~d[7-s] : 1'b0;
        return 1'b0;
    endfunction

    task automatic wb_write(input logic [31:0] w);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_we = 1'b1; wb_wdata = w;
        @(posedge clk); #1;
        chk("wr_ack", 32'(wb_ack), 32'd1);
        wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic csr_read(input string tag);
        @(posedge clk); #1;
        wb_cyc = 1'b1;
        @(posedge clk); #1;
        chk("rd_ack", 32'(wb_ack), 32'd1);
        chk(tag, wb_rdata, {1'b1, 22'b0, exp_ack, exp_data});
        wb_cyc = 1'b0;
        @(posedge clk); #1;
        chk("rd_ack_pulse", 32'(wb_ack), 32'd0);
        chk("rd_idle_zero", wb_rdata, 32'd0);
    endtask

    // Issue one primitive, follow it clock by clock, and read status either on the last busy
    // clock (late=0) or on the first clock after completion (late=1).
    task automatic run_cmd(input logic [1:0] cmd, input logic [7:0] d, input logic ai, input logic sa,
                           input bit late, input int busy_k);
        int n, r;
        logic [7:0] nd;
        logic na;
        n = cmd[1] ? 36 : 4;
        r = 16 * n + (late ? 1 : 0);
        nd = cmd[1] ? d : exp_data;
        na = (cmd == 2'd2) ? ~sa : (cmd == 2'd3) ? ai : exp_ack;
        wb_write({18'b0, cmd, 3'b0, ai, (cmd == 2'd3) ? 8'h00 : d});
        for (int k = 0; k <= r; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k % 64 == 0) pull = slave_pull(cmd, d, sa, k / 64);
            if (k % 16 == 0 || k % 16 == 15)
                chk($sformatf("lines c%0d k%0d", cmd, k), 32'({scl_oe, sda_oe}), 32'(exp_lines(cmd, d, ai, k, exp_scl)));
            if (busy_k > 0 && k == busy_k) begin wb_cyc = 1'b1; wb_we = 1'b1; wb_wdata = 32'h1000; end
            if (busy_k > 0 && k == busy_k + 1) begin
                chk("busy_ack", 32'(wb_ack), 32'd1);
                wb_cyc = 1'b0; wb_we = 1'b0;
            end
            if (k == r - 1) wb_cyc = 1'b1;
            if (k == r) begin
                chk("status_ack", 32'(wb_ack), 32'd1);
                chk(late ? "status_done" : "status_busy", wb_rdata,
                    late ? {1'b1, 22'b0, na, nd} : {1'b0, 22'b0, exp_ack, exp_data});
                wb_cyc = 1'b0;
            end
        end
        exp_data = nd;
        exp_ack = na;
        exp_scl = (cmd == 2'd1) ? 1'b0 : 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", 32'(scl_oe), 32'd0);
        chk("rst_sda", 32'(sda_oe), 32'd0);
        chk("rst_ack", 32'(wb_ack), 32'd0);
        chk("rst_rdata", wb_rdata, 32'd0);
        rst = 1'b0;
        csr_read("csr_reset");
        run_cmd(2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        csr_read("after_start");
        run_cmd(2'd2, 8'hA5, 1'b0, 1'b1, 1'b0, 100);
        csr_read("write_a5");
        run_cmd(2'd3, 8'h3C, 1'b1, 1'b0, 1'b1, 0);
        run_cmd(2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 0);
        repeat (4) begin
            run_cmd(2'd2 + 2'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), $urandom_range(0, 1) * 300);
            csr_read("random_byte");
        end
        run_cmd(2'd1, 8'h00, 1'b0, 1'b0, 1'b1, 0);
        csr_read("after_stop");
        run_cmd(2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 0);
        d = 8'($urandom);
        wb_write({18'b0, 2'd2, 4'b0, d});
        repeat (200) @(posedge clk);
        #1;
        chk("pre_reset_lines", 32'({scl_oe, sda_oe}), 32'(exp_lines(2'd2, d, 1'b0, 200, exp_scl)));
        rst = 1'b1;
        #1;
        chk("mid_rst_scl", 32'(scl_oe), 32'd0);
        chk("mid_rst_sda", 32'(sda_oe), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_data = 8'h00;
        exp_ack = 1'b0;
        exp_scl = 1'b0;
        csr_read("after_mid_reset");
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
